// File: rtl/score_display_pkg.sv
// Shared constants and types for the score display.
//   SEG_BLANK : all segments off (active-low)
//   SEG_CODES : gfedcba active-low patterns for digits 0..9 (index = digit)
//   state_t   : conversion FSM states
package score_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [9:0][6:0] SEG_CODES = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        UPDATE
    } state_t;

endpackage

// File: rtl/seg_digit_decode.sv
// Combinational BCD digit to active-low 7-segment decoder.
//   bcd   : 4-bit BCD digit
//   blank : 1 forces all segments off
//   seg_c : segments, bit 6 = g ... bit 0 = a, active-low
// Non-BCD codes decode to blank.
module seg_digit_decode
    import score_display_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        if (!blank && (bcd <= 4'd9)) begin
            seg_c = SEG_CODES[bcd];
        end
    end

endmodule

// File: rtl/score_display.sv
// Binary score to NDIGITS-digit active-low 7-segment display.
// A sequential double-dabble engine converts one bit per clock; the result
// is held in a display register with leading-zero blanking and saturation
// to all 9s when the score does not fit.
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   load     : start conversion of value (accepted only when idle)
//   value    : WIDTH-bit binary score
//   busy     : conversion in progress
//   done     : one-cycle pulse when the display register updates
//   overflow : displayed value is saturated (score > 10^NDIGITS-1)
//   leds     : 7 segments per digit, digit k at [7k+6:7k], digit 0 = LSD
//   blink    : (SCORE_BLINK_EN only) blink all digits while high
// Optional feature macro: SCORE_BLINK_EN.
module score_display
    import score_display_pkg::*;
#(
    parameter int unsigned WIDTH     = 14,
    parameter int unsigned NDIGITS   = 4,
    parameter int unsigned BLANK_LZ  = 1,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load,
    input  logic [WIDTH-1:0]       value,
`ifdef SCORE_BLINK_EN
    input  logic                   blink,
`endif
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic [7*NDIGITS-1:0]   leds
);

    localparam int unsigned BW = 4 * NDIGITS;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [BW-1:0]    bcd;
    logic             sticky;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    disp;

    logic [BW-1:0]    bcd_adj_c;
    logic             sticky_c;
    logic [BW-1:0]    bcd_sh_c;
    logic [WIDTH-1:0] sreg_sh_c;
    logic             last_c;
    logic [BW-1:0]    disp_d_c;
    logic             ovf_d_c;
    logic             force_blank_c;

    // One double-dabble step plus the next display-register value.
    // The display update is committed on the final shift so that done and
    // the new leds appear together in the UPDATE cycle.
    always_comb begin
        bcd_adj_c = bcd;
        for (int i = 0; i < int'(NDIGITS); i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj_c[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        sticky_c               = sticky | bcd_adj_c[BW-1];
        {bcd_sh_c, sreg_sh_c}  = {bcd_adj_c[BW-2:0], sreg, 1'b0};
        last_c                 = (state == SHIFT) && (cnt == CW'(1));
        disp_d_c               = disp;
        ovf_d_c                = overflow;
        if (last_c) begin
            if (sticky_c) begin
                disp_d_c = {NDIGITS{4'd9}};
                ovf_d_c  = 1'b1;
            end else begin
                disp_d_c = bcd_sh_c;
                ovf_d_c  = 1'b0;
            end
        end
    end

    // Conversion FSM and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            sreg     <= '0;
            bcd      <= '0;
            sticky   <= 1'b0;
            cnt      <= '0;
            disp     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done     <= 1'b0;
            disp     <= disp_d_c;
            overflow <= ovf_d_c;
            case (state)
                IDLE: begin
                    if (load) begin
                        sreg   <= value;
                        bcd    <= '0;
                        sticky <= 1'b0;
                        cnt    <= CW'(WIDTH);
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd    <= bcd_sh_c;
                    sreg   <= sreg_sh_c;
                    sticky <= sticky_c;
                    cnt    <= cnt - CW'(1);
                    if (last_c) begin
                        done  <= 1'b1;
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SCORE_BLINK_EN
    localparam int unsigned DW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [DW-1:0] div_cnt;
    logic          phase;

    // Free-running blink phase, toggles every BLINK_DIV cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else if (div_cnt == DW'(BLINK_DIV - 1)) begin
            div_cnt <= '0;
            phase   <= ~phase;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    assign force_blank_c = blink & phase;
`else
    logic unused_blink_div;
    assign unused_blink_div = ^32'(BLINK_DIV);
    assign force_blank_c    = 1'b0;
`endif

    // zero_above_c[k]: every nibble at position k and higher is zero.
    logic [NDIGITS:0]   zero_above_c;
    logic [NDIGITS-1:0] blank_c;
    logic [7*NDIGITS-1:0] seg_c;

    assign zero_above_c[NDIGITS] = 1'b1;

    for (genvar k = 0; k < int'(NDIGITS); k++) begin : g_digit
        assign zero_above_c[k] = zero_above_c[k+1] && (disp_d_c[4*k +: 4] == 4'd0);
        assign blank_c[k]      = (k != 0) && (BLANK_LZ != 0) && !ovf_d_c && zero_above_c[k];

        seg_digit_decode u_dec (
            .bcd   (disp_d_c[4*k +: 4]),
            .blank (blank_c[k]),
            .seg_c (seg_c[7*k +: 7])
        );
    end

    // Segment outputs, decoded from the next display value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < int'(NDIGITS); k++) begin
                leds[7*k +: 7] <= ((k == 0) || (BLANK_LZ == 0)) ? SEG_CODES[0] : SEG_BLANK;
            end
        end else begin
            leds <= force_blank_c ? {NDIGITS{SEG_BLANK}} : seg_c;
        end
    end

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: directed vector table plus
// hand-written sequences for load-while-busy, mid-conversion reset and blink.
module tb_score_display;

    logic        clk;
    logic        reset_n;
    logic        load;
    logic [13:0] value;
    logic        blink;
    logic        busy, done, overflow;
    logic [27:0] leds;
    logic        busy_n, done_n, overflow_n;
    logic [27:0] leds_n;

    int n_chk  = 0;
    int n_fail = 0;

    score_display #(.WIDTH(14), .NDIGITS(4), .BLANK_LZ(1), .BLINK_DIV(4)) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .value    (value),
`ifdef SCORE_BLINK_EN
        .blink    (blink),
`endif
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .leds     (leds)
    );

    score_display #(.WIDTH(14), .NDIGITS(4), .BLANK_LZ(0), .BLINK_DIV(4)) u_nolz (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .value    (value),
`ifdef SCORE_BLINK_EN
        .blink    (blink),
`endif
        .busy     (busy_n),
        .done     (done_n),
        .overflow (overflow_n),
        .leds     (leds_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one conversion and watch cycles 1..16 after acceptance.
    task automatic run_conv(input logic [13:0] v, output int done_cyc, output int done_cnt,
                            output int busy_bad, output int hold_bad);
        logic [27:0] old;
        old      = leds;
        done_cyc = -1;
        done_cnt = 0;
        busy_bad = 0;
        hold_bad = 0;
        load  = 1'b1;
        value = v;
        step();
        load  = 1'b0;
        value = 14'($urandom);
        for (int c = 1; c <= 16; c++) begin
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if ((c <= 15) != busy) busy_bad++;
            if ((c < 15) && (leds !== old)) hold_bad++;
            if (c < 16) step();
        end
    endtask

    typedef struct {
        logic [13:0] val;
        logic [27:0] lz;
        logic [27:0] nolz;
        logic        ovf;
    } vec_t;

    vec_t vecs[10];

    localparam logic [27:0] RST_LZ   = {7'h7F, 7'h7F, 7'h7F, 7'h40};
    localparam logic [27:0] RST_NOLZ = {7'h40, 7'h40, 7'h40, 7'h40};
    localparam logic [27:0] ALL9     = {7'h10, 7'h10, 7'h10, 7'h10};

    initial begin
        int dc, dn, bb, hb;
        int blank_cnt, bad_blink, bad_steady;
        logic s [24];

        vecs[0] = '{14'd1234,  {7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19}, 1'b0};
        vecs[1] = '{14'd7,     {7'h7F, 7'h7F, 7'h7F, 7'h78}, {7'h40, 7'h40, 7'h40, 7'h78}, 1'b0};
        vecs[2] = '{14'd0,     RST_LZ,                       RST_NOLZ,                     1'b0};
        vecs[3] = '{14'd10000, ALL9,                         ALL9,                         1'b1};
        vecs[4] = '{14'd16383, ALL9,                         ALL9,                         1'b1};
        vecs[5] = '{14'd9999,  ALL9,                         ALL9,                         1'b0};
        vecs[6] = '{14'd50,    {7'h7F, 7'h7F, 7'h12, 7'h40}, {7'h40, 7'h40, 7'h12, 7'h40}, 1'b0};
        vecs[7] = '{14'd1005,  {7'h79, 7'h40, 7'h40, 7'h12}, {7'h79, 7'h40, 7'h40, 7'h12}, 1'b0};
        vecs[8] = '{14'd100,   {7'h7F, 7'h79, 7'h40, 7'h40}, {7'h40, 7'h79, 7'h40, 7'h40}, 1'b0};
        vecs[9] = '{14'd10000, ALL9,                         ALL9,                         1'b1};

        reset_n = 1'b0;
        load    = 1'b0;
        value   = '0;
        blink   = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();

        chk("reset_leds",      32'(leds),     32'(RST_LZ));
        chk("reset_leds_nolz", 32'(leds_n),   32'(RST_NOLZ));
        chk("reset_busy",      32'(busy),     32'd0);
        chk("reset_done",      32'(done),     32'd0);
        chk("reset_overflow",  32'(overflow), 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_conv(vecs[i].val, dc, dn, bb, hb);
            chk($sformatf("v%0d_done_cycle", i), 32'(dc), 32'd15);
            chk($sformatf("v%0d_done_count", i), 32'(dn), 32'd1);
            chk($sformatf("v%0d_busy_window", i), 32'(bb), 32'd0);
            chk($sformatf("v%0d_leds_hold", i), 32'(hb), 32'd0);
            chk($sformatf("v%0d_leds", i), 32'(leds), 32'(vecs[i].lz));
            chk($sformatf("v%0d_leds_nolz", i), 32'(leds_n), 32'(vecs[i].nolz));
            chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].ovf));
        end

        // Load 55, then a second load of 99 in cycle 5 that must be ignored.
        load  = 1'b1;
        value = 14'd55;
        step();
        load  = 1'b0;
        dn = 0;
        dc = -1;
        for (int c = 1; c <= 35; c++) begin
            if (c == 5) begin
                load  = 1'b1;
                value = 14'd99;
            end
            if (c == 6) load = 1'b0;
            if (done) begin
                dn++;
                if (dc < 0) dc = c;
            end
            step();
        end
        chk("busy_load_done_cycle", 32'(dc), 32'd15);
        chk("busy_load_done_count", 32'(dn), 32'd1);
        chk("busy_load_leds", 32'(leds), 32'({7'h7F, 7'h7F, 7'h12, 7'h12}));
        chk("busy_load_overflow", 32'(overflow), 32'd0);

        // Saturate, then reset in cycle 8 of a new conversion.
        run_conv(14'd12000, dc, dn, bb, hb);
        chk("pre_reset_overflow", 32'(overflow), 32'd1);
        load  = 1'b1;
        value = 14'd1234;
        step();
        load  = 1'b0;
        repeat (7) step();
        reset_n = 1'b0;
        #1;
        chk("midreset_busy",      32'(busy),     32'd0);
        chk("midreset_overflow",  32'(overflow), 32'd0);
        chk("midreset_leds",      32'(leds),     32'(RST_LZ));
        chk("midreset_leds_nolz", 32'(leds_n),   32'(RST_NOLZ));
        step();
        reset_n = 1'b1;
        dn = 0;
        for (int c = 0; c < 20; c++) begin
            if (done) dn++;
            step();
        end
        chk("midreset_no_done",   32'(dn),   32'd0);
        chk("midreset_leds_held", 32'(leds), 32'(RST_LZ));

        run_conv(14'd42, dc, dn, bb, hb);
        chk("post_reset_done_cycle", 32'(dc), 32'd15);
        chk("post_reset_leds", 32'(leds), 32'({7'h7F, 7'h7F, 7'h19, 7'h24}));

`ifdef SCORE_BLINK_EN
        blink = 1'b1;
        step();
        step();
        blank_cnt = 0;
        bad_blink = 0;
        for (int i = 0; i < 24; i++) begin
            s[i] = (leds === {4{7'h7F}});
            if (s[i]) blank_cnt++;
            else if (leds !== {7'h7F, 7'h7F, 7'h19, 7'h24}) bad_blink++;
            if ((i >= 4) && (s[i] == s[i-4])) bad_blink++;
            step();
        end
        chk("blink_pattern", 32'(bad_blink), 32'd0);
        chk("blink_blank_count", 32'(blank_cnt), 32'd12);
        blink = 1'b0;
        step();
        step();
        bad_steady = 0;
        for (int i = 0; i < 12; i++) begin
            if (leds !== {7'h7F, 7'h7F, 7'h19, 7'h24}) bad_steady++;
            step();
        end
        chk("blink_off_steady", 32'(bad_steady), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
